// File: rtl/quad_sample_pkg.sv
// Shared types and constants for the quadrature sample controller.
package quad_sample_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } stream_state_t;

  localparam int SEQ_W       = 8;
  localparam int MIN_PERIOD  = 2;
  localparam int HDR_OVR_BIT = 15;
  localparam int HDR_SEQ_LSB = 0;

endpackage

// File: rtl/qsc_window_timer.sv
// Window timer: holds the period register (clamped to MIN_PERIOD), supports restart
// on a configuration write and emits a registered one-cycle tick on every wrap.
module qsc_window_timer
  import quad_sample_pkg::*;
#(
  parameter int PERIOD_W   = 32,
  parameter int DEF_PERIOD = 100000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_cfg_period,
  input  logic                i_cfg_period_wr,
  output logic                o_tick
);

  localparam logic [PERIOD_W-1:0] L_DEF_PERIOD =
    PERIOD_W'((DEF_PERIOD < MIN_PERIOD) ? MIN_PERIOD : DEF_PERIOD);

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] w_cfg_clamped;
  logic                w_wrap;

  assign w_cfg_clamped = (i_cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                 : i_cfg_period;
  assign w_wrap        = i_enable && (r_timer == (r_period - PERIOD_W'(1)));

  // A restart that lands on a wrap still issues that wrap's tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_period <= L_DEF_PERIOD;
      r_timer  <= '0;
      o_tick   <= 1'b0;
    end else begin
      o_tick <= w_wrap;
      if (i_cfg_period_wr) begin
        r_period <= w_cfg_clamped;
        r_timer  <= '0;
      end else if (!i_enable || w_wrap) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_sample_ctrl.sv
// Quadrature sample sequencer: window ticks, per-window delta capture and snapshot frame
// streaming over valid/ready. Define QSC_FRAME_HDR_EN to prepend the seq/overrun header word.
module quad_sample_ctrl
  import quad_sample_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int PERIOD_W   = 32,
  parameter int DEF_PERIOD = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PERIOD_W-1:0]   cfg_period,
  input  logic                  cfg_period_wr,
  input  logic [N_CH*CNT_W-1:0] ch_delta,
  output logic                  ch_clear,
  output logic                  sample_tick,
  input  logic                  frame_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  stream_state_t         r_state, w_next_state;
  logic [IDX_W-1:0]      r_idx, w_next_idx;
  logic [N_CH*CNT_W-1:0] r_live, r_frame;
  logic [SEQ_W-1:0]      r_seq;
  logic                  r_overrun, r_unread;
  logic                  w_tick, w_snap;
  logic [CNT_W-1:0]      w_word;

  qsc_window_timer #(
    .PERIOD_W  (PERIOD_W),
    .DEF_PERIOD(DEF_PERIOD)
  ) u_timer (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_cfg_period   (cfg_period),
    .i_cfg_period_wr(cfg_period_wr),
    .o_tick         (w_tick)
  );

  assign ch_clear    = w_tick;
  assign sample_tick = w_tick;
  assign busy        = (r_state != S_IDLE);
  assign w_word      = r_frame[int'(r_idx)*CNT_W +: CNT_W];

`ifdef QSC_FRAME_HDR_EN
  logic [SEQ_W-1:0] r_seq_snap;
  logic             r_ovr_snap;
  logic [CNT_W-1:0] w_hdr;

  always_comb begin
    w_hdr                       = '0;
    w_hdr[HDR_OVR_BIT]          = r_ovr_snap;
    w_hdr[HDR_SEQ_LSB +: SEQ_W] = r_seq_snap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_snap <= '0;
      r_ovr_snap <= 1'b0;
    end else if (w_snap) begin
      r_seq_snap <= r_seq;
      r_ovr_snap <= r_overrun;
    end
  end
`endif

  // A snapshot coinciding with a capture takes the old live bank; the new capture stays unread.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live    <= '0;
      r_frame   <= '0;
      r_seq     <= '0;
      r_overrun <= 1'b0;
      r_unread  <= 1'b0;
    end else begin
      if (w_snap) begin
        r_frame <= r_live;
      end
      if (w_tick) begin
        r_live    <= ch_delta;
        r_seq     <= r_seq + SEQ_W'(1);
        r_unread  <= 1'b1;
        r_overrun <= w_snap ? r_overrun : (r_overrun | r_unread);
      end else if (w_snap) begin
        r_unread  <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_snap       = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_req) begin
          w_snap     = 1'b1;
          w_next_idx = '0;
`ifdef QSC_FRAME_HDR_EN
          w_next_state = S_HDR;
`else
          w_next_state = S_DATA;
`endif
        end
      end
`ifdef QSC_FRAME_HDR_EN
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = w_hdr;
        if (out_ready) begin
          w_next_state = S_DATA;
          w_next_idx   = '0;
        end
      end
`endif
      S_DATA: begin
        out_valid = 1'b1;
        out_data  = w_word;
        out_last  = (r_idx == LAST_IDX);
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = S_IDLE;
            w_next_idx   = '0;
          end else begin
            w_next_idx = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_quad_sample_ctrl.sv
// Directed self-checking bench for quad_sample_ctrl; follows QSC_FRAME_HDR_EN for frame layout.
`timescale 1ns/1ps
module tb_quad_sample_ctrl;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 16;
  localparam int PERIOD_W   = 32;
  localparam int DEF_PERIOD = 40;
`ifdef QSC_FRAME_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int NWORDS = HDR_WORDS + N_CH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [PERIOD_W-1:0]   cfg_period;
  logic                  cfg_period_wr;
  logic [N_CH*CNT_W-1:0] ch_delta;
  logic                  ch_clear;
  logic                  sample_tick;
  logic                  frame_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      out_data;
  logic                  out_last;
  logic                  busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  quad_sample_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_W(PERIOD_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_period(cfg_period),
    .cfg_period_wr(cfg_period_wr), .ch_delta(ch_delta), .ch_clear(ch_clear),
    .sample_tick(sample_tick), .frame_req(frame_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; cfg_period = '0; cfg_period_wr = 1'b0;
    ch_delta = '0; frame_req = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_period(input logic [PERIOD_W-1:0] val);
    cfg_period = val; cfg_period_wr = 1'b1;
    @(negedge clk);
    cfg_period_wr = 1'b0;
  endtask

  // Returns number of negedges until sample_tick is seen, or the bound on timeout.
  task automatic wait_tick(input int bound, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_tick && cnt < bound);
  endtask

  task automatic drain_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    int unsigned t1;
    reset = 1'b1; enable = 1'b1; frame_req = 1'b1; out_ready = 1'b1;
    cfg_period = '0; cfg_period_wr = 1'b0; ch_delta = '1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL rst_data got %h want 0000", out_data); end
    checks++; if (busy !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_last got %b%b want 00", busy, out_last); end
    checks++; if (sample_tick !== 1'b0 || ch_clear !== 1'b0) begin errors++; $display("[TB] FAIL rst_tick got %b%b want 00", sample_tick, ch_clear); end
    frame_req = 1'b0; out_ready = 1'b0; ch_delta = '0;
    reset = 1'b0;
    wait_tick(200, cnt);
    t1 = cyc;
    checks++; if (cnt !== DEF_PERIOD) begin errors++; $display("[TB] FAIL first_tick got %0d want %0d", cnt, DEF_PERIOD); end
    checks++; if (ch_clear !== 1'b1) begin errors++; $display("[TB] FAIL clear_with_tick got %b want 1", ch_clear); end
    @(negedge clk);
    checks++; if (sample_tick !== 1'b0 || ch_clear !== 1'b0) begin errors++; $display("[TB] FAIL tick_width got %b%b want 00", sample_tick, ch_clear); end
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL frame1_start got %b%b want 11", out_valid, busy); end
`ifdef QSC_FRAME_HDR_EN
    checks++; if (out_data !== 16'h0001) begin errors++; $display("[TB] FAIL seq1_hdr got %h want 0001", out_data); end
`endif
    drain_frame();
    wait_tick(200, cnt);
    checks++; if (cyc - t1 !== DEF_PERIOD) begin errors++; $display("[TB] FAIL second_tick got %0d want %0d", cyc - t1, DEF_PERIOD); end
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
`ifdef QSC_FRAME_HDR_EN
    checks++; if (out_data !== 16'h0002) begin errors++; $display("[TB] FAIL seq2_hdr got %h want 0002", out_data); end
`else
    checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL seq2_word0 got %h want 0000", out_data); end
`endif
    drain_frame();
  endtask

  task automatic test_frame();
    int cnt;
    logic [CNT_W-1:0] exp [NWORDS];
    do_reset();
    enable = 1'b1;
    write_period(10);
    ch_delta = {16'h0000, 16'h0000, 16'hFFFD, 16'h0005};
`ifdef QSC_FRAME_HDR_EN
    exp[0] = 16'h0001;
`endif
    exp[HDR_WORDS+0] = 16'h0005; exp[HDR_WORDS+1] = 16'hFFFD;
    exp[HDR_WORDS+2] = 16'h0000; exp[HDR_WORDS+3] = 16'h0000;
    wait_tick(100, cnt);
    checks++; if (cnt !== 10) begin errors++; $display("[TB] FAIL frame_period got %0d want 10", cnt); end
    @(negedge clk);
    frame_req = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[w] || out_last !== (w == NWORDS-1)) begin
        errors++;
        $display("[TB] FAIL frame_word%0d got v%b %h l%b want v1 %h l%b", w, out_valid, out_data, out_last, exp[w], (w == NWORDS-1));
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_end got %b%b want 00", out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int cnt;
    int w;
    int c;
    logic [CNT_W-1:0] exp [NWORDS];
    do_reset();
    enable = 1'b1;
    write_period(4);
    ch_delta = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
`ifdef QSC_FRAME_HDR_EN
    exp[0] = 16'h0001;
`endif
    exp[HDR_WORDS+0] = 16'h4444; exp[HDR_WORDS+1] = 16'h3333;
    exp[HDR_WORDS+2] = 16'h2222; exp[HDR_WORDS+3] = 16'h1111;
    wait_tick(100, cnt);
    @(negedge clk);
    ch_delta = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    w = 0; c = 0;
    while (w < NWORDS && c < 100) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[w] || out_last !== (w == NWORDS-1)) begin
        errors++;
        $display("[TB] FAIL stall_word%0d_c%0d got v%b %h l%b want v1 %h l%b", w, c, out_valid, out_data, out_last, exp[w], (w == NWORDS-1));
      end
      out_ready = ((c % 3) == 2);
      @(negedge clk);
      if (out_ready) w++;
      c++;
    end
    out_ready = 1'b0;
    checks++; if (w !== NWORDS) begin errors++; $display("[TB] FAIL stall_count got %0d want %0d", w, NWORDS); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_end got %b want 0", out_valid); end
  endtask

  task automatic test_overrun();
    int cnt;
    int ticks;
    logic [CNT_W-1:0] exp [NWORDS];
    do_reset();
    enable = 1'b1;
    write_period(5);
    ch_delta = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
`ifdef QSC_FRAME_HDR_EN
    exp[0] = 16'h8002;
`endif
    exp[HDR_WORDS+0] = 16'h0001; exp[HDR_WORDS+1] = 16'h0002;
    exp[HDR_WORDS+2] = 16'h0003; exp[HDR_WORDS+3] = 16'h0004;
    wait_tick(50, cnt);
    wait_tick(50, cnt);
    checks++; if (cnt !== 5) begin errors++; $display("[TB] FAIL ovr_period got %0d want 5", cnt); end
    @(negedge clk);
    enable = 1'b0; frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < NWORDS; w++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[w]) begin
        errors++;
        $display("[TB] FAIL ovr_word%0d got v%b %h want v1 %h", w, out_valid, out_data, exp[w]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    ticks = 0;
    repeat (15) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("[TB] FAIL disabled_ticks got %0d want 0", ticks); end
    enable = 1'b1;
    wait_tick(50, cnt);
    checks++; if (cnt !== 5) begin errors++; $display("[TB] FAIL reenable_tick got %0d want 5", cnt); end
    @(negedge clk);
    enable = 1'b0; frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
`ifdef QSC_FRAME_HDR_EN
    checks++; if (out_data !== 16'h0003) begin errors++; $display("[TB] FAIL ovr_cleared_hdr got %h want 0003", out_data); end
`else
    checks++; if (out_data !== 16'h0001) begin errors++; $display("[TB] FAIL ovr_cleared_word0 got %h want 0001", out_data); end
`endif
    drain_frame();
  endtask

  task automatic test_period_cfg();
    int cnt;
    do_reset();
    enable = 1'b1;
    write_period(0);
    wait_tick(50, cnt);
    checks++; if (cnt !== 2) begin errors++; $display("[TB] FAIL clamp_first got %0d want 2", cnt); end
    wait_tick(50, cnt);
    checks++; if (cnt !== 2) begin errors++; $display("[TB] FAIL clamp_next got %0d want 2", cnt); end
    write_period(20);
    wait_tick(50, cnt);
    checks++; if (cnt !== 20) begin errors++; $display("[TB] FAIL period20 got %0d want 20", cnt); end
    repeat (5) @(negedge clk);
    write_period(7);
    wait_tick(50, cnt);
    checks++; if (cnt !== 7) begin errors++; $display("[TB] FAIL restart7 got %0d want 7", cnt); end
    wait_tick(50, cnt);
    checks++; if (cnt !== 7) begin errors++; $display("[TB] FAIL period7 got %0d want 7", cnt); end
    write_period(3);
    wait_tick(50, cnt);
    @(negedge clk);
    @(negedge clk);
    cfg_period = 6; cfg_period_wr = 1'b1;
    @(negedge clk);
    cfg_period_wr = 1'b0;
    checks++; if (sample_tick !== 1'b1) begin errors++; $display("[TB] FAIL wr_on_wrap_tick got %b want 1", sample_tick); end
    wait_tick(50, cnt);
    checks++; if (cnt !== 6) begin errors++; $display("[TB] FAIL wr_on_wrap_next got %0d want 6", cnt); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_reset();
    enable = 1'b1;
    write_period(10);
    ch_delta = {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01};
    wait_tick(50, cnt);
    @(negedge clk);
    frame_req = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int w = 0; w < NWORDS; w++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word%0d valid got %b want 1", w, out_valid); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b%b want 00", out_valid, busy); end
    @(negedge clk);
    frame_req = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart got %b%b want 11", out_valid, busy); end
`ifdef QSC_FRAME_HDR_EN
    checks++; if (out_data !== 16'h0001) begin errors++; $display("[TB] FAIL b2b_hdr got %h want 0001", out_data); end
`else
    checks++; if (out_data !== 16'h0E01) begin errors++; $display("[TB] FAIL b2b_word0 got %h want 0e01", out_data); end
`endif
    drain_frame();
  endtask

  task automatic test_reset_mid_frame();
    int cnt;
    int words;
    do_reset();
    enable = 1'b1;
    write_period(6);
    ch_delta = {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00};
    wait_tick(50, cnt);
    @(negedge clk);
    frame_req = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    repeat (HDR_WORDS + 2) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0D02) begin errors++; $display("[TB] FAIL mid_idx2 got v%b %h want v1 0d02", out_valid, out_data); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort got %b%b want 00", out_valid, busy); end
    checks++; if (out_data !== 16'h0000 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL abort_data got %h l%b want 0000 l0", out_data, out_last); end
    write_period(3);
    wait_tick(50, cnt);
    checks++; if (cnt !== 3) begin errors++; $display("[TB] FAIL post_rst_tick got %0d want 3", cnt); end
    @(negedge clk);
    enable = 1'b0; frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
`ifdef QSC_FRAME_HDR_EN
    checks++; if (out_data !== 16'h0001) begin errors++; $display("[TB] FAIL post_rst_seq got %h want 0001", out_data); end
`else
    checks++; if (out_data !== 16'h0D00) begin errors++; $display("[TB] FAIL post_rst_word0 got %h want 0d00", out_data); end
`endif
    out_ready = 1'b1;
    words = 0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      words++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (words !== NWORDS) begin errors++; $display("[TB] FAIL frame_len got %0d want %0d", words, NWORDS); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_overrun();
    test_period_cfg();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
